// File: rtl/uart_cmd_frame_decoder_if.sv
// uart_cmd_frame_decoder_if: byte-stream input and decoded command record bundle.
interface uart_cmd_frame_decoder_if #(parameter int ADDR_WIDTH = 4);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  cmd_ready;
   logic                  cmd_valid;
   logic [1:0]            cmd_type;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [7:0]            cmd_data;
   logic [7:0]            cmd_op_a;
   logic [7:0]            cmd_op_b;
   logic [3:0]            cmd_fun;
   logic                  frame_err;
   logic [1:0]            err_code;
   modport master (
      input  rx_data, rx_valid, cmd_ready,
      output cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b, cmd_fun, frame_err, err_code
   );
   modport slave (
      output rx_data, rx_valid, cmd_ready,
      input  cmd_valid, cmd_type, cmd_addr, cmd_data, cmd_op_a, cmd_op_b, cmd_fun, frame_err, err_code
   );
endinterface

// File: rtl/uart_cmd_frame_decoder.sv
// uart_cmd_frame_decoder: parses host command frames into records behind a one-entry valid/ready register.
module uart_cmd_frame_decoder #(
   parameter int         ADDR_WIDTH  = 4,
   parameter int         TIMEOUT_CYC = 4096,
   parameter logic [7:0] CMD_WR      = 8'hAA,
   parameter logic [7:0] CMD_RD      = 8'hBB,
   parameter logic [7:0] CMD_ALU_OP  = 8'hCC,
   parameter logic [7:0] CMD_ALU_NOP = 8'hDD
) (
   input logic                        CLK,
   input logic                        RST_n,
   uart_cmd_frame_decoder_if.master   bus
);
   typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, OP_FUN, NOP_FUN} state_t;
   localparam int CW = TIMEOUT_CYC > 0 ? $clog2(TIMEOUT_CYC + 1) : 1;
   state_t                state, nxt;
   logic [CW-1:0]         cnt;
   logic [ADDR_WIDTH-1:0] addr_q, n_addr;
   logic [7:0]            op_a_q, op_b_q, n_data, n_op_a, n_op_b;
   logic [3:0]            n_fun;
   logic [1:0]            n_type, code;
   logic                  done, err, timeout, addr_ok, fun_ok, load, ovf;
   assign addr_ok = (bus.rx_data >> ADDR_WIDTH) == 8'd0;
   assign fun_ok  = bus.rx_data[7:4] == 4'd0;
   // the incoming byte wins over a timeout that would fire in the same cycle
   assign timeout = (TIMEOUT_CYC != 0) && state != IDLE && !bus.rx_valid && cnt == CW'(TIMEOUT_CYC - 1);
   assign load    = done && (!bus.cmd_valid || bus.cmd_ready);
   assign ovf     = done && bus.cmd_valid && !bus.cmd_ready;
   always_comb begin
      nxt    = state;
      done   = 1'b0;
      err    = 1'b0;
      code   = 2'd2;
      n_type = 2'd0;
      n_addr = '0;
      n_data = 8'd0;
      n_op_a = 8'd0;
      n_op_b = 8'd0;
      n_fun  = 4'd0;
      if (timeout) begin
         nxt  = IDLE;
         err  = 1'b1;
         code = 2'd3;
      end else if (bus.rx_valid) begin
         case (state)
            IDLE: begin
               nxt  = bus.rx_data == CMD_WR ? WR_ADDR : bus.rx_data == CMD_RD ? RD_ADDR :
                      bus.rx_data == CMD_ALU_OP ? OP_A : bus.rx_data == CMD_ALU_NOP ? NOP_FUN : IDLE;
               err  = nxt == IDLE;
               code = 2'd1;
            end
            WR_ADDR: begin
               nxt = addr_ok ? WR_DATA : IDLE;
               err = !addr_ok;
            end
            WR_DATA: begin
               nxt    = IDLE;
               done   = 1'b1;
               n_addr = addr_q;
               n_data = bus.rx_data;
            end
            RD_ADDR: begin
               nxt    = IDLE;
               err    = !addr_ok;
               done   = addr_ok;
               n_type = 2'd1;
               n_addr = bus.rx_data[ADDR_WIDTH-1:0];
            end
            OP_A: nxt = OP_B;
            OP_B: nxt = OP_FUN;
            OP_FUN: begin
               nxt    = IDLE;
               err    = !fun_ok;
               done   = fun_ok;
               n_type = 2'd2;
               n_op_a = op_a_q;
               n_op_b = op_b_q;
               n_fun  = bus.rx_data[3:0];
            end
            NOP_FUN: begin
               nxt    = IDLE;
               err    = !fun_ok;
               done   = fun_ok;
               n_type = 2'd3;
               n_fun  = bus.rx_data[3:0];
            end
            default: nxt = IDLE;
         endcase
      end
   end
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state  <= IDLE;
         cnt    <= '0;
         addr_q <= '0;
         op_a_q <= 8'd0;
         op_b_q <= 8'd0;
      end else begin
         state  <= nxt;
         cnt    <= (TIMEOUT_CYC == 0 || bus.rx_valid || state == IDLE || timeout) ? '0 : cnt + CW'(cnt != '1);
         addr_q <= (bus.rx_valid && state == WR_ADDR && addr_ok) ? bus.rx_data[ADDR_WIDTH-1:0] : addr_q;
         op_a_q <= (bus.rx_valid && state == OP_A) ? bus.rx_data : op_a_q;
         op_b_q <= (bus.rx_valid && state == OP_B) ? bus.rx_data : op_b_q;
      end
   end
   // overflow drops the new record and leaves the pending one untouched
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         bus.cmd_valid <= 1'b0;
         bus.cmd_type  <= 2'd0;
         bus.cmd_addr  <= '0;
         bus.cmd_data  <= 8'd0;
         bus.cmd_op_a  <= 8'd0;
         bus.cmd_op_b  <= 8'd0;
         bus.cmd_fun   <= 4'd0;
         bus.frame_err <= 1'b0;
         bus.err_code  <= 2'd0;
      end else begin
         if (load) begin
            bus.cmd_valid <= 1'b1;
            bus.cmd_type  <= n_type;
            bus.cmd_addr  <= n_addr;
            bus.cmd_data  <= n_data;
            bus.cmd_op_a  <= n_op_a;
            bus.cmd_op_b  <= n_op_b;
            bus.cmd_fun   <= n_fun;
         end else if (bus.cmd_ready) begin
            bus.cmd_valid <= 1'b0;
         end
         bus.frame_err <= err || ovf;
         bus.err_code  <= ovf ? 2'd0 : err ? code : bus.err_code;
      end
   end
endmodule

// File: tb/tb_uart_cmd_frame_decoder.sv
// tb_uart_cmd_frame_decoder: directed frames with hand-computed records, errors and timeout boundaries.
module tb_uart_cmd_frame_decoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   err_pulses = 0;
   int   snap;
   int   held;
   uart_cmd_frame_decoder_if #(.ADDR_WIDTH(4)) bus();
   uart_cmd_frame_decoder #(.ADDR_WIDTH(4), .TIMEOUT_CYC(16)) dut (.CLK(clk), .RST_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) if (bus.frame_err) err_pulses++;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask
   task automatic rec(input string tag, input logic [1:0] t, input logic [3:0] a, input logic [7:0] d,
                      input logic [7:0] oa, input logic [7:0] ob, input logic [3:0] f);
      chk({tag, "_valid"}, 32'(bus.cmd_valid), 32'd1);
      chk({tag, "_type"}, 32'(bus.cmd_type), 32'(t));
      chk({tag, "_addr"}, 32'(bus.cmd_addr), 32'(a));
      chk({tag, "_data"}, 32'(bus.cmd_data), 32'(d));
      chk({tag, "_opa"}, 32'(bus.cmd_op_a), 32'(oa));
      chk({tag, "_opb"}, 32'(bus.cmd_op_b), 32'(ob));
      chk({tag, "_fun"}, 32'(bus.cmd_fun), 32'(f));
   endtask
   initial begin
      bus.rx_data   = 8'd0;
      bus.rx_valid  = 1'b0;
      bus.cmd_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
      chk("rst_err", 32'(bus.frame_err), 32'd0);
      chk("rst_code", 32'(bus.err_code), 32'd0);
      chk("rst_type", 32'(bus.cmd_type), 32'd0);
      // write frame, consumer ready
      bus.cmd_ready = 1'b1;
      snap = err_pulses;
      send(8'hAA); send(8'h05); send(8'h3C);
      rec("wr", 2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      chk("wr_drop", 32'(bus.cmd_valid), 32'd0);
      chk("wr_noerr", 32'(err_pulses - snap), 32'd0);
      // ALU frame held under backpressure for 11 cycles
      bus.cmd_ready = 1'b0;
      send(8'hCC); send(8'h12); send(8'h34); send(8'h03);
      held = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.cmd_valid && bus.cmd_type == 2'd2 && bus.cmd_op_a == 8'h12 && bus.cmd_op_b == 8'h34 && bus.cmd_fun == 4'h3)
            held++;
         @(negedge clk);
      end
      chk("alu_hold_cycles", 32'(held), 32'd10);
      rec("alu", 2'd2, 4'h0, 8'h00, 8'h12, 8'h34, 4'h3);
      bus.cmd_ready = 1'b1;
      @(negedge clk);
      chk("alu_drop", 32'(bus.cmd_valid), 32'd0);
      // illegal opcode, then address out of range, then clean NOP
      send(8'h55);
      chk("ill_err", 32'(bus.frame_err), 32'd1);
      chk("ill_code", 32'(bus.err_code), 32'd1);
      send(8'hBB);
      chk("ill_pulse_end", 32'(bus.frame_err), 32'd0);
      send(8'h1F);
      chk("rng_err", 32'(bus.frame_err), 32'd1);
      chk("rng_code", 32'(bus.err_code), 32'd2);
      chk("rng_novalid", 32'(bus.cmd_valid), 32'd0);
      send(8'hDD); send(8'h0F);
      rec("nop", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF);
      chk("nop_code_held", 32'(bus.err_code), 32'd2);
      @(negedge clk);
      // 15-cycle gap survives, 16-cycle gap times out
      send(8'hAA); send(8'h02);
      snap = err_pulses;
      repeat (15) @(negedge clk);
      send(8'h77);
      rec("gap15", 2'd0, 4'h2, 8'h77, 8'h00, 8'h00, 4'h0);
      chk("gap15_noerr", 32'(err_pulses - snap), 32'd0);
      @(negedge clk);
      send(8'hAA); send(8'h02);
      repeat (15) @(negedge clk);
      chk("to_early", 32'(bus.frame_err), 32'd0);
      @(negedge clk);
      chk("to_err", 32'(bus.frame_err), 32'd1);
      chk("to_code", 32'(bus.err_code), 32'd3);
      send(8'hBB); send(8'h02);
      rec("after_to", 2'd1, 4'h2, 8'h00, 8'h00, 8'h00, 4'h0);
      @(negedge clk);
      // overflow drops new record; ready on completion replaces it
      bus.cmd_ready = 1'b0;
      send(8'hBB); send(8'h01);
      rec("ovf_first", 2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
      send(8'hDD); send(8'h04);
      chk("ovf_err", 32'(bus.frame_err), 32'd1);
      chk("ovf_code", 32'(bus.err_code), 32'd0);
      rec("ovf_kept", 2'd1, 4'h1, 8'h00, 8'h00, 8'h00, 4'h0);
      send(8'hDD);
      bus.cmd_ready = 1'b1;
      send(8'h04);
      rec("replace", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h4);
      chk("replace_noerr", 32'(bus.frame_err), 32'd0);
      @(negedge clk);
      chk("replace_drop", 32'(bus.cmd_valid), 32'd0);
      // asynchronous reset mid-frame with a record pending
      bus.cmd_ready = 1'b0;
      send(8'hDD); send(8'h07);
      send(8'h55);
      chk("pre_rst_code", 32'(bus.err_code), 32'd1);
      send(8'hCC); send(8'hAA);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.cmd_valid), 32'd0);
      chk("arst_fun", 32'(bus.cmd_fun), 32'd0);
      chk("arst_type", 32'(bus.cmd_type), 32'd0);
      chk("arst_code", 32'(bus.err_code), 32'd0);
      chk("arst_err", 32'(bus.frame_err), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(8'hDD); send(8'h02);
      rec("post_rst", 2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2);
      chk("post_rst_noerr", 32'(bus.frame_err), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
